// File: rtl/sram22_512x32_arbiter.sv
// sram22_512x32_arbiter
// Two-port round-robin front end for one single-port sram22 512x32 macro.
// After reset it can zero-fill the macro. It then serves one access per cycle.
// Read data comes back one cycle after the grant and is taken straight from the macro.
module sram22_512x32_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WMASK_WIDTH = 4,
   parameter int INIT_ZERO   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   init_done,
   input  logic                   p0_valid,
   output logic                   p0_ready,
   input  logic                   p0_we,
   input  logic [WMASK_WIDTH-1:0] p0_wmask,
   input  logic [ADDR_WIDTH-1:0]  p0_addr,
   input  logic [DATA_WIDTH-1:0]  p0_wdata,
   output logic                   p0_rvalid,
   output logic [DATA_WIDTH-1:0]  p0_rdata,
   input  logic                   p1_valid,
   output logic                   p1_ready,
   input  logic                   p1_we,
   input  logic [WMASK_WIDTH-1:0] p1_wmask,
   input  logic [ADDR_WIDTH-1:0]  p1_addr,
   input  logic [DATA_WIDTH-1:0]  p1_wdata,
   output logic                   p1_rvalid,
   output logic [DATA_WIDTH-1:0]  p1_rdata,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
   localparam logic [ADDR_WIDTH-1:0] FILL_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] FILL_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_r;
   state_t                  state_s;
   logic [ADDR_WIDTH-1:0]   fill_r;
   logic                    last_r;      // index of the port granted most recently
   logic                    init_done_r;
   logic                    rvalid0_r;
   logic                    rvalid1_r;
   logic                    gnt0_s;
   logic                    gnt1_s;
   logic                    we_s;

   // Round-robin grant. On a tie the port that was not granted last wins. No grant while in reset.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_r == ST_RUN) && !rst) begin
         if (p0_valid && p1_valid) begin
            gnt0_s = last_r;
            gnt1_s = ~last_r;
         end else begin
            gnt0_s = p0_valid;
            gnt1_s = p1_valid;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Next state and macro pin muxing: the fill pattern in INIT, the granted port's fields in RUN.
   always_comb begin
      state_s    = state_r;
      we_s       = 1'b0;
      sram_wmask = {WMASK_WIDTH{1'b0}};
      sram_addr  = {ADDR_WIDTH{1'b0}};
      sram_din   = {DATA_WIDTH{1'b0}};
      case (state_r)
         ST_INIT: begin
            we_s       = 1'b1;
            sram_wmask = {WMASK_WIDTH{1'b1}};
            sram_addr  = fill_r;
            sram_din   = {DATA_WIDTH{1'b0}};
            if (fill_r == FILL_LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            state_s = ST_RUN;
            if (gnt0_s) begin
               we_s       = p0_we;
               sram_wmask = p0_wmask;
               sram_addr  = p0_addr;
               sram_din   = p0_wdata;
            end else if (gnt1_s) begin
               we_s       = p1_we;
               sram_wmask = p1_wmask;
               sram_addr  = p1_addr;
               sram_din   = p1_wdata;
            end else begin
               // An idle cycle becomes a read of address 0. Its result is discarded.
               we_s       = 1'b0;
               sram_wmask = {WMASK_WIDTH{1'b0}};
               sram_addr  = {ADDR_WIDTH{1'b0}};
               sram_din   = {DATA_WIDTH{1'b0}};
            end
         end
         default: begin
            state_s = RST_STATE;
         end
      endcase
   end

   // Hold the macro write enable low for as long as reset is asserted, including mid-fill.
   assign sram_we = we_s & ~rst;

   // State register and fill counter. Reset restarts the fill at address 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RST_STATE;
         fill_r  <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         if (state_r == ST_INIT) begin
            fill_r <= fill_r + FILL_ONE;
         end else begin
            fill_r <= fill_r;
         end
      end
   end

   // init_done goes high on the same edge that enters RUN. RUN is never left, so it stays high until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= (state_s == ST_RUN);
      end
   end

   // Remember the last granted port. Cycles with no grant leave it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_r <= 1'b1;
      end else if (gnt0_s) begin
         last_r <= 1'b0;
      end else if (gnt1_s) begin
         last_r <= 1'b1;
      end else begin
         last_r <= last_r;
      end
   end

   // Read response flags. Each is high for the one cycle after a granted read. Reset clears them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
      end else begin
         rvalid0_r <= gnt0_s & ~p0_we;
         rvalid1_r <= gnt1_s & ~p1_we;
      end
   end

   assign init_done = init_done_r;
   assign p0_ready  = gnt0_s;
   assign p1_ready  = gnt1_s;
   assign p0_rvalid = rvalid0_r;
   assign p1_rvalid = rvalid1_r;
   assign p0_rdata  = sram_dout;
   assign p1_rdata  = sram_dout;

endmodule

// File: tb/tb_sram22_512x32_arbiter.sv
// Directed testbench for sram22_512x32_arbiter. It includes a behavioural model of the macro.
module tb_sram22_512x32_arbiter;

   logic        clk;
   logic        rst;
   logic        init_done;
   logic        p0_valid, p0_ready, p0_we, p0_rvalid;
   logic [3:0]  p0_wmask;
   logic [8:0]  p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic        p1_valid, p1_ready, p1_we, p1_rvalid;
   logic [3:0]  p1_wmask;
   logic [8:0]  p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic        sram_we;
   logic [3:0]  sram_wmask;
   logic [8:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   logic [31:0] mem [0:511];
   logic        preload;
   int          checks;
   int          errors;
   int          bad;
   logic        e0;
   logic        e1;

   sram22_512x32_arbiter #(
      .DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4), .INIT_ZERO(1)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_wmask(p0_wmask),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_wmask(p1_wmask),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Macro model: registered dout, byte-lane writes, and dout undefined after a write.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A50000 | 32'(i);
      end else if (sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         sram_dout <= 32'hBAD0BAD0;
      end else begin
         sram_dout <= mem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_p0(input logic v, input logic we, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d);
      p0_valid = v; p0_we = we; p0_wmask = m; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set_p1(input logic v, input logic we, input logic [3:0] m,
                         input logic [8:0] a, input logic [31:0] d);
      p1_valid = v; p1_we = we; p1_wmask = m; p1_addr = a; p1_wdata = d;
   endtask

   initial begin
      checks = 0; errors = 0; bad = 0;
      rst = 1'b1; preload = 1'b1;
      set_p0(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
      set_p1(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
      @(negedge clk); preload = 1'b0;
      @(negedge clk);
      // Outputs while reset is held
      chk("rst_init_done", init_done, 32'd0);
      chk("rst_p0_ready", p0_ready, 32'd0);
      chk("rst_p1_ready", p1_ready, 32'd0);
      chk("rst_p0_rvalid", p0_rvalid, 32'd0);
      chk("rst_p1_rvalid", p1_rvalid, 32'd0);
      chk("rst_sram_we", sram_we, 32'd0);

      // Zero-fill sequence. Both ports request throughout and must not be accepted.
      rst = 1'b0;
      set_p0(1'b1, 1'b0, 4'h0, 9'd0, 32'h0);
      set_p1(1'b1, 1'b0, 4'h0, 9'd0, 32'h0);
      for (int k = 0; k < 512; k++) begin
         #1;
         if (sram_we !== 1'b1 || sram_addr !== 9'(k) || sram_din !== 32'h0 ||
             sram_wmask !== 4'hF || p0_ready !== 1'b0 || p1_ready !== 1'b0 ||
             init_done !== 1'b0) bad++;
         if (k == 511) begin
            p0_valid = 1'b0; p1_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("fill_bad_cycles", 32'(bad), 32'd0);
      #1;
      chk("init_done_at_512", init_done, 32'd1);
      chk("run_idle_we", sram_we, 32'd0);

      // p0 full-word write to address 5, then a read of address 5
      set_p0(1'b1, 1'b1, 4'hF, 9'd5, 32'hDEADBEEF);
      #1;
      chk("p0_wr_ready", p0_ready, 32'd1);
      chk("p0_wr_p1_ready", p1_ready, 32'd0);
      chk("p0_wr_sram_we", sram_we, 32'd1);
      chk("p0_wr_addr", sram_addr, 32'd5);
      chk("p0_wr_din", sram_din, 32'hDEADBEEF);
      @(negedge clk);
      set_p0(1'b1, 1'b0, 4'h0, 9'd5, 32'h0);
      #1;
      chk("p0_rd_ready", p0_ready, 32'd1);
      chk("p0_rd_sram_we", sram_we, 32'd0);
      chk("p0_no_write_ack", p0_rvalid, 32'd0);
      @(negedge clk);
      p0_valid = 1'b0;
      #1;
      chk("p0_rvalid", p0_rvalid, 32'd1);
      chk("p0_rdata", p0_rdata, 32'hDEADBEEF);
      chk("p0_rd_p1_rvalid", p1_rvalid, 32'd0);

      // p1 masked write (lanes 0 and 2), then read-after-write of the same address
      set_p1(1'b1, 1'b1, 4'b0101, 9'd5, 32'h11223344);
      #1;
      chk("p1_wr_ready", p1_ready, 32'd1);
      chk("p1_wr_mask", sram_wmask, 32'h5);
      @(negedge clk);
      set_p1(1'b1, 1'b0, 4'h0, 9'd5, 32'h0);
      #1;
      chk("p0_rvalid_one_cycle", p0_rvalid, 32'd0);
      chk("p1_no_write_ack", p1_rvalid, 32'd0);
      @(negedge clk);
      set_p1(1'b1, 1'b0, 4'h0, 9'd7, 32'h0);
      #1;
      chk("p1_rvalid", p1_rvalid, 32'd1);
      chk("p1_rdata_masked", p1_rdata, 32'hDE22BE44);
      @(negedge clk);
      p1_valid = 1'b0;
      #1;
      chk("p1_rvalid_b2b", p1_rvalid, 32'd1);
      chk("p1_rdata_zero_fill", p1_rdata, 32'h0);

      // Both ports read every cycle. p1 was granted last, so p0 is granted first.
      set_p0(1'b1, 1'b0, 4'h0, 9'd5, 32'h0);
      set_p1(1'b1, 1'b0, 4'h0, 9'd7, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         e0 = ((i % 2) == 0);
         chk("rr_p0_ready", p0_ready, 32'(e0));
         chk("rr_p1_ready", p1_ready, 32'(!e0));
         if (i > 0) begin
            e1 = (((i - 1) % 2) == 0);
            chk("rr_p0_rvalid", p0_rvalid, 32'(e1));
            chk("rr_p1_rvalid", p1_rvalid, 32'(!e1));
            if (e1) chk("rr_p0_rdata", p0_rdata, 32'hDE22BE44);
            else chk("rr_p1_rdata", p1_rdata, 32'h0);
         end
         @(negedge clk);
      end
      p0_valid = 1'b0; p1_valid = 1'b0;
      #1;
      chk("rr_last_p1_rvalid", p1_rvalid, 32'd1);
      chk("rr_last_p0_rvalid", p0_rvalid, 32'd0);

      // Reset while a read response is in flight
      @(negedge clk);
      set_p0(1'b1, 1'b0, 4'h0, 9'd5, 32'h0);
      @(posedge clk);
      #1;
      p0_valid = 1'b0;
      chk("inflight_rvalid", p0_rvalid, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rvalid_drop", p0_rvalid, 32'd0);
      chk("async_init_done_drop", init_done, 32'd0);
      chk("rst_run_sram_we", sram_we, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_held_sram_we", sram_we, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_rvalid", p0_rvalid, 32'd0);
      chk("refill_start_we", sram_we, 32'd1);
      chk("refill_start_addr", sram_addr, 32'd0);

      // Reset during the fill at address 200
      repeat (200) @(negedge clk);
      #1;
      chk("fill_at_200", sram_addr, 32'd200);
      rst = 1'b1;
      #1;
      chk("midfill_rst_we", sram_we, 32'd0);
      chk("midfill_rst_ready", p0_ready, 32'd0);
      @(negedge clk);
      #1;
      chk("midfill_rst_held_we", sram_we, 32'd0);
      rst = 1'b0;
      #1;
      chk("fill_restart_addr", sram_addr, 32'd0);
      chk("fill_restart_we", sram_we, 32'd1);
      chk("fill_restart_done", init_done, 32'd0);
      repeat (511) @(negedge clk);
      #1;
      chk("refill_addr_511", sram_addr, 32'd511);
      chk("refill_done_low_511", init_done, 32'd0);
      @(negedge clk);
      #1;
      chk("refill_done_512", init_done, 32'd1);

      // Address 5 reads back zero after the second fill
      set_p0(1'b1, 1'b0, 4'h0, 9'd5, 32'h0);
      @(negedge clk);
      p0_valid = 1'b0;
      #1;
      chk("refill_rvalid", p0_rvalid, 32'd1);
      chk("refill_rdata", p0_rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
